// File: rtl/sn76489_pkg.sv
// Shared types and helpers for the SN76489 register-write scheduler.
// Covers register indices, FSM state and byte formatting.
package sn76489_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STROBE   = 2'd1,
        ST_WAIT_RDY = 2'd2,
        ST_GAP      = 2'd3
    } wr_state_e;

    localparam logic [2:0] REG_T1_FREQ = 3'd0;
    localparam logic [2:0] REG_T1_ATT  = 3'd1;
    localparam logic [2:0] REG_T2_FREQ = 3'd2;
    localparam logic [2:0] REG_T2_ATT  = 3'd3;
    localparam logic [2:0] REG_T3_FREQ = 3'd4;
    localparam logic [2:0] REG_T3_ATT  = 3'd5;
    localparam logic [2:0] REG_N_CTRL  = 3'd6;
    localparam logic [2:0] REG_N_ATT   = 3'd7;

    localparam int LATCH_BIT = 7;

    function automatic logic is_freq_reg(input logic [2:0] r);
        return (r == REG_T1_FREQ) || (r == REG_T2_FREQ) ||
               (r == REG_T3_FREQ);
    endfunction

    // Noise control only carries three meaningful bits in the latch nibble.
    function automatic logic [7:0] latch_byte(input logic [2:0] r,
                                              input logic [3:0] lo);
        logic [7:0] b;
        b = {1'b0, r, (r == REG_N_CTRL) ? {1'b0, lo[2:0]} : lo};
        b[LATCH_BIT] = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/sn76489_rr_arb.sv
// Round-robin requester pick with a pointer that advances only on grant.
// The pointer resets to the last requester so requester 0 wins first.
module sn76489_rr_arb
    import sn76489_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock_i,
    input  logic               res_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               upd_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] idx_d;
    logic          found;

    always_comb begin
        found = 1'b0;
        idx_d = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IW-1:0] j;
            j = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_i[j]) begin
                found = 1'b1;
                idx_d = j;
            end
        end
    end

    assign idx_o  = idx_d;
    assign any_o  = found;
    assign pick_o = found ? (NUM_REQ'(1) << idx_d) : '0;

    always_ff @(posedge clock_i or negedge res_n_i) begin
        if (!res_n_i) begin
            ptr_q <= IW'(NUM_REQ - 1);
        end else if (upd_i && found) begin
            ptr_q <= idx_d;
        end
    end

endmodule

// File: rtl/sn76489_wr_sched.sv
// Serialises register writes from several masters onto the SN76489 bus,
// one latch(/data) byte sequence at a time with READY handshake and timeout.
module sn76489_wr_sched
    import sn76489_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clock_i,
    input  logic                  res_n_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*3-1:0]  reg_i,
    input  logic [NUM_REQ*10-1:0] data_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  ce_n_o,
    output logic                  we_n_o,
    output logic [7:0]            d_o,
    input  logic                  ready_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    wr_state_e          state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               strb_n_q, strb_n_d;
    logic [7:0]         d_q, d_d;
    logic [7:0]         dbyte_q, dbyte_d;
    logic               pend_q, pend_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      win;
    logic               any_req;
    logic               take;
    logic [2:0]         sel_reg;
    logic [9:0]         sel_data;
    logic               ack_lo, ack_hi, expired;

    assign take     = (state_q == ST_IDLE) && any_req;
    assign sel_reg  = reg_i[int'(win) * 3 +: 3];
    assign sel_data = data_i[int'(win) * 10 +: 10];
    assign ack_lo   = (state_q == ST_STROBE) && !ready_i;
    assign ack_hi   = (state_q == ST_WAIT_RDY) && ready_i;
    assign expired  = (cnt_q == CW'(TIMEOUT_CYC - 1));

    sn76489_rr_arb #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clock_i(clock_i),
        .res_n_i(res_n_i),
        .req_i  (req_i),
        .upd_i  (take),
        .pick_o (pick),
        .idx_o  (win),
        .any_o  (any_req)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        strb_n_d = strb_n_q;
        d_d      = d_q;
        dbyte_d  = dbyte_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    gnt_d    = pick;
                    busy_d   = 1'b1;
                    strb_n_d = 1'b0;
                    d_d      = latch_byte(sel_reg, sel_data[3:0]);
                    dbyte_d  = {2'b00, sel_data[9:4]};
                    pend_d   = is_freq_reg(sel_reg);
                    cnt_d    = '0;
                    state_d  = ST_STROBE;
                end
            end
            ST_STROBE, ST_WAIT_RDY: begin
                if (ack_hi) begin
                    strb_n_d = 1'b1;
                    state_d  = ST_GAP;
                end else if (expired) begin
                    // Abort: free the bus and forget any pending data byte.
                    strb_n_d = 1'b1;
                    err_d    = 1'b1;
                    pend_d   = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (ack_lo) begin
                        state_d = ST_WAIT_RDY;
                    end
                end
            end
            ST_GAP: begin
                if (pend_q) begin
                    pend_d   = 1'b0;
                    d_d      = dbyte_q;
                    strb_n_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_STROBE;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            strb_n_q <= 1'b1;
            d_q      <= '0;
            dbyte_q  <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            strb_n_q <= strb_n_d;
            d_q      <= d_d;
            dbyte_q  <= dbyte_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign ce_n_o = strb_n_q;
    assign we_n_o = strb_n_q;
    assign d_o    = d_q;

endmodule
